// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: ALU result stream, mult/div result handshake,
// hazard query port and the registered regfile write port.
interface writeback_arbiter_if #(
    parameter int PTRW = 2
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [31:0]     alu_data;
    logic            md_valid;
    logic            md_ready;
    logic [4:0]      md_rd;
    logic [31:0]     md_data;
    logic [4:0]      ctrl_queryReg;
    logic            query_pending;
    logic [PTRW:0]   md_count;
    logic            ctrl_writeEnable;
    logic [4:0]      ctrl_writeReg;
    logic [31:0]     data_writeReg;

    // Upstream side: produces results and queries, observes the write port.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output md_valid, md_rd, md_data,
        output ctrl_queryReg,
        input  md_ready, query_pending, md_count,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  md_valid, md_rd, md_data,
        input  ctrl_queryReg,
        output md_ready, query_pending, md_count,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: ALU results always win the single regfile write port;
// mult/div results wait in an in-order queue and drain on idle ALU cycles.
// A newer ALU write to the same register kills any queued mult/div result
// (WAW), which then pops without a write strobe.
module writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic          clock,
    input  logic          ctrl_reset,
    writeback_arbiter_if.slave bus
);
    localparam logic [PTRW:0] DEPTH_CNT = (PTRW+1)'(DEPTH);

    // Queue storage; rd/data have no reset, only the live bits do.
    logic [4:0]        rd_mem   [DEPTH];
    logic [31:0]       data_mem [DEPTH];
    logic [DEPTH-1:0]  live_reg;
    logic [DEPTH-1:0]  occupied;
    logic [DEPTH-1:0]  query_hit;

    logic [PTRW-1:0]   wr_ptr_reg;
    logic [PTRW-1:0]   rd_ptr_reg;
    logic [PTRW:0]     count_reg;

    logic              write_en_reg;
    logic [4:0]        write_rd_reg;
    logic [31:0]       write_data_reg;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              alu_kill;
    logic              push_live;
    logic [4:0]        head_rd;
    logic [31:0]       head_data;
    logic              head_live;

    assign full  = (count_reg == DEPTH_CNT);
    assign empty = (count_reg == '0);

    // Ready is purely !full, so a full queue never enqueues even while popping.
    assign push = bus.md_valid && !full;
    // The head only drains on cycles the ALU leaves the write port idle.
    assign pop  = !bus.alu_valid && !empty;

    assign alu_kill = bus.alu_valid && (bus.alu_rd != 5'd0);

    // A concurrent ALU result is younger than the mult/div result, so it
    // overwrites it: the queued copy is born dead. r0 writes are always dead.
    assign push_live = (bus.md_rd != 5'd0) &&
                       !(bus.alu_valid && (bus.alu_rd == bus.md_rd));

    // Head read is combinational: a popped entry must reach the output
    // register at the same edge it is selected.
    assign head_rd   = rd_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];
    assign head_live = live_reg[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTRW-1:0] offset;

            // Slot distance from the head, modulo DEPTH; occupied if within count.
            assign offset        = PTRW'(gi) - rd_ptr_reg;
            assign occupied[gi]  = ({1'b0, offset} < count_reg);
            assign query_hit[gi] = occupied[gi] && live_reg[gi] &&
                                   (rd_mem[gi] == bus.ctrl_queryReg) &&
                                   (bus.ctrl_queryReg != 5'd0);

            // Live bit: set on enqueue, cleared by a matching ALU write.
            always_ff @(posedge clock or posedge ctrl_reset) begin
                if (ctrl_reset) begin
                    live_reg[gi] <= 1'b0;
                end else if (push && (wr_ptr_reg == PTRW'(gi))) begin
                    live_reg[gi] <= push_live;
                end else if (alu_kill && (rd_mem[gi] == bus.alu_rd)) begin
                    live_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Entry payload capture on enqueue.
    always_ff @(posedge clock) begin
        if (push) begin
            rd_mem[wr_ptr_reg]   <= bus.md_rd;
            data_mem[wr_ptr_reg] <= bus.md_data;
        end
    end

    // Queue pointers and occupancy; killed entries still occupy a slot.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Registered regfile write port: ALU first, else queue head, else idle.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            write_en_reg   <= 1'b0;
            write_rd_reg   <= '0;
            write_data_reg <= '0;
        end else if (bus.alu_valid) begin
            write_en_reg   <= (bus.alu_rd != 5'd0);
            write_rd_reg   <= bus.alu_rd;
            write_data_reg <= bus.alu_data;
        end else if (pop) begin
            write_en_reg   <= head_live && (head_rd != 5'd0);
            write_rd_reg   <= head_rd;
            write_data_reg <= head_data;
        end else begin
            write_en_reg   <= 1'b0;
        end
    end

    assign bus.md_ready         = !full;
    assign bus.query_pending    = |query_hit;
    assign bus.md_count         = count_reg;
    assign bus.ctrl_writeEnable = write_en_reg;
    assign bus.ctrl_writeReg    = write_rd_reg;
    assign bus.data_writeReg    = write_data_reg;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a small regfile model that
// commits the write port on the negedge.
module tb_writeback_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] rf [32];

    writeback_arbiter_if #(.PTRW(2)) bus ();

    writeback_arbiter #(.DEPTH(4), .PTRW(2)) dut (
        .clock      (clk),
        .ctrl_reset (rst),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model: commits on the negedge after the write appears.
    always @(negedge clk) begin
        if (bus.ctrl_writeEnable && bus.ctrl_writeReg != 5'd0)
            rf[bus.ctrl_writeReg] <= bus.data_writeReg;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] data);
        chk({tag, "_we"}, 32'(bus.ctrl_writeEnable), 32'(we));
        if (we) begin
            chk({tag, "_rd"}, 32'(bus.ctrl_writeReg), 32'(rd));
            chk({tag, "_data"}, bus.data_writeReg, data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rst = 1'b1;
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.md_valid = 0;  bus.md_rd = 0;  bus.md_data = 0;
        bus.ctrl_queryReg = 0;

        // Reset state
        #3;
        chk("rst_ready", 32'(bus.md_ready), 32'd1);
        chk("rst_count", 32'(bus.md_count), 32'd0);
        chk("rst_we", 32'(bus.ctrl_writeEnable), 32'd0);
        chk("rst_wreg", 32'(bus.ctrl_writeReg), 32'd0);
        chk("rst_wdata", bus.data_writeReg, 32'd0);
        tick(); tick();
        rst = 1'b0;

        // Test 1: reset mid-stream with 3 queued entries
        bus.alu_valid = 1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11;
        for (int i = 0; i < 3; i++) begin
            bus.md_valid = 1; bus.md_rd = 5'(21 + i); bus.md_data = 32'h300 + 32'(i);
            tick();
        end
        chk("t1_count3", 32'(bus.md_count), 32'd3);
        chk("t1_we_before", 32'(bus.ctrl_writeEnable), 32'd1);
        bus.md_valid = 0; bus.alu_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_count", 32'(bus.md_count), 32'd0);
        chk("t1_rst_we", 32'(bus.ctrl_writeEnable), 32'd0);
        chk("t1_rst_ready", 32'(bus.md_ready), 32'd1);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_idle_we", 32'(bus.ctrl_writeEnable), 32'd0);
        end
        @(negedge clk); #1;
        chk("t1_rf21", rf[21], 32'h0);
        chk("t1_rf23", rf[23], 32'h0);

        // Test 2: single md result through the queue
        bus.md_valid = 1; bus.md_rd = 5'd5; bus.md_data = 32'hDEADBEEF;
        tick();
        bus.md_valid = 0;
        chk("t2_count1", 32'(bus.md_count), 32'd1);
        chk("t2_no_bypass", 32'(bus.ctrl_writeEnable), 32'd0);
        tick();
        chk_wr("t2_wr", 1'b1, 5'd5, 32'hDEADBEEF);
        chk("t2_count0", 32'(bus.md_count), 32'd0);
        tick();
        chk("t2_idle_we", 32'(bus.ctrl_writeEnable), 32'd0);
        chk("t2_hold_rd", 32'(bus.ctrl_writeReg), 32'd5);
        chk("t2_hold_data", bus.data_writeReg, 32'hDEADBEEF);

        // Test 3: 6 ALU cycles while 5 md results are offered
        j = 0;
        for (int k = 0; k < 6; k++) begin
            bus.alu_valid = 1; bus.alu_rd = 5'(10 + k); bus.alu_data = 32'h100 + 32'(k);
            bus.md_valid = (j < 5); bus.md_rd = 5'(16 + j); bus.md_data = 32'h200 + 32'(j);
            #1;
            chk("t3_ready", 32'(bus.md_ready), 32'(k < 4));
            if (bus.md_ready && bus.md_valid) j++;
            tick();
            chk_wr("t3_alu", 1'b1, 5'(10 + k), 32'h100 + 32'(k));
        end
        bus.alu_valid = 0;
        bus.md_rd = 5'(16 + j); bus.md_data = 32'h200 + 32'(j);
        #1;
        chk("t3_count_full", 32'(bus.md_count), 32'd4);
        chk("t3_ready_full_pop", 32'(bus.md_ready), 32'd0);
        tick();
        chk_wr("t3_md0", 1'b1, 5'd16, 32'h200);
        chk("t3_ready_space", 32'(bus.md_ready), 32'd1);
        tick();
        bus.md_valid = 0;
        chk_wr("t3_md1", 1'b1, 5'd17, 32'h201);
        chk("t3_count_after5", 32'(bus.md_count), 32'd3);
        for (int k = 2; k < 5; k++) begin
            tick();
            chk_wr("t3_md", 1'b1, 5'(16 + k), 32'h200 + 32'(k));
        end
        chk("t3_count0", 32'(bus.md_count), 32'd0);

        // Test 4: queued md rd=7 killed by a later ALU rd=7
        bus.ctrl_queryReg = 5'd7;
        bus.md_valid = 1; bus.md_rd = 5'd7; bus.md_data = 32'h1;
        #1;
        chk("t4_qp_before", 32'(bus.query_pending), 32'd0);
        tick();
        bus.md_valid = 0;
        chk("t4_qp_queued", 32'(bus.query_pending), 32'd1);
        bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'h2;
        tick();
        bus.alu_valid = 0;
        chk_wr("t4_alu", 1'b1, 5'd7, 32'h2);
        chk("t4_qp_killed", 32'(bus.query_pending), 32'd0);
        chk("t4_count1", 32'(bus.md_count), 32'd1);
        tick();
        chk("t4_dead_we", 32'(bus.ctrl_writeEnable), 32'd0);
        chk("t4_count0", 32'(bus.md_count), 32'd0);
        @(negedge clk); #1;
        chk("t4_rf7", rf[7], 32'h2);

        // Test 5: md rd=0 and ALU rd=0
        bus.ctrl_queryReg = 5'd0;
        bus.md_valid = 1; bus.md_rd = 5'd0; bus.md_data = 32'h55;
        bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_data = 32'h66;
        tick();
        bus.md_valid = 0; bus.alu_valid = 0;
        chk("t5_alu_we", 32'(bus.ctrl_writeEnable), 32'd0);
        chk("t5_count1", 32'(bus.md_count), 32'd1);
        chk("t5_qp_r0", 32'(bus.query_pending), 32'd0);
        tick();
        chk("t5_md_we", 32'(bus.ctrl_writeEnable), 32'd0);
        chk("t5_count0", 32'(bus.md_count), 32'd0);

        // Test 6: same-cycle md rd=9 and ALU rd=9
        bus.ctrl_queryReg = 5'd9;
        bus.md_valid = 1; bus.md_rd = 5'd9; bus.md_data = 32'hA;
        bus.alu_valid = 1; bus.alu_rd = 5'd9; bus.alu_data = 32'hB;
        tick();
        bus.md_valid = 0; bus.alu_valid = 0;
        chk_wr("t6_alu", 1'b1, 5'd9, 32'hB);
        chk("t6_qp", 32'(bus.query_pending), 32'd0);
        chk("t6_count1", 32'(bus.md_count), 32'd1);
        tick();
        chk("t6_dead_we", 32'(bus.ctrl_writeEnable), 32'd0);
        chk("t6_count0", 32'(bus.md_count), 32'd0);
        @(negedge clk); #1;
        chk("t6_rf9", rf[9], 32'hB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
